// File: rtl/mdu_ctrl_pkg.sv
// Shared definitions for the multiply/divide sequencer: op encodings,
// FSM states, default latencies and op-class helpers.
package mdu_ctrl_pkg;

    localparam int unsigned MULT_CYCLES_DEF = 5;
    localparam int unsigned DIV_CYCLES_DEF  = 10;

    // Countdown width; latencies up to 255 cycles fit.
    localparam int unsigned CNT_W = 8;

    typedef enum logic [2:0] {
        MD_NONE  = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MTHI  = 3'd5,
        MD_MTLO  = 3'd6
    } md_op_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Ops that occupy the unit for multiple cycles.
    function automatic logic is_long_op(input md_op_t op);
        return (op == MD_MULT) || (op == MD_MULTU) ||
               (op == MD_DIV)  || (op == MD_DIVU);
    endfunction

    function automatic logic is_div_op(input md_op_t op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/mdu_ctrl_if.sv
// E-stage <-> MDU signal bundle. The E stage (master) presents an op with
// start; the MDU (slave) returns HI/LO, busy and the stall request.
interface mdu_ctrl_if;
    import mdu_ctrl_pkg::*;

    // Handshake: an op is accepted on the rising edge where start=1, kill=0
    // and busy=0. While busy=1 any start is dropped; md_stall tells the
    // hazard unit to hold D so that MD ops never arrive while busy.
    logic        start;
    md_op_t      md_op;
    logic        kill;
    logic [31:0] A;
    logic [31:0] B;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        md_stall;

    modport master (
        output start, md_op, kill, A, B,
        input  hi, lo, busy, md_stall
    );

    modport slave (
        input  start, md_op, kill, A, B,
        output hi, lo, busy, md_stall
    );

endinterface

// File: rtl/mdu_ctrl_compute.sv
// Combinational multiply/divide datapath (md_compute): latched operands and
// op in, the 64-bit {hi,lo} result and a divide-by-zero flag out.
module mdu_ctrl_compute
    import mdu_ctrl_pkg::*;
(
    input  md_op_t      op_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [31:0] hi_next_o,
    output logic [31:0] lo_next_o,
    output logic        div_by_zero_o
);

    logic signed [63:0] a_sx;
    logic signed [63:0] b_sx;
    logic        [63:0] prod_s;
    logic        [63:0] prod_u;
    logic        [31:0] b_nz;
    logic        [31:0] a_mag;
    logic        [31:0] b_mag;
    logic        [31:0] uq;
    logic        [31:0] ur;
    logic        [31:0] sq_mag;
    logic        [31:0] sr_mag;
    logic        [31:0] sq;
    logic        [31:0] sr;

    always_comb begin
        a_sx   = {{32{a_i[31]}}, a_i};
        b_sx   = {{32{b_i[31]}}, b_i};
        prod_s = a_sx * b_sx;
        prod_u = {32'd0, a_i} * {32'd0, b_i};

        // A zero divisor is replaced by 1 only to keep the divider defined;
        // the result is discarded by the controller in that case.
        b_nz   = (b_i == 32'd0) ? 32'd1 : b_i;
        uq     = a_i / b_nz;
        ur     = a_i % b_nz;

        // Signed divide on magnitudes: 0x80000000 / -1 falls out as
        // 0x80000000 rem 0 through the unsigned path with no special case.
        a_mag  = a_i[31]  ? (32'd0 - a_i)  : a_i;
        b_mag  = b_nz[31] ? (32'd0 - b_nz) : b_nz;
        sq_mag = a_mag / b_mag;
        sr_mag = a_mag % b_mag;
        sq     = (a_i[31] ^ b_i[31]) ? (32'd0 - sq_mag) : sq_mag;
        sr     = a_i[31] ? (32'd0 - sr_mag) : sr_mag;

        hi_next_o = 32'd0;
        lo_next_o = 32'd0;
        case (op_i)
            MD_MULT:  {hi_next_o, lo_next_o} = prod_s;
            MD_MULTU: {hi_next_o, lo_next_o} = prod_u;
            MD_DIV:   begin hi_next_o = sr; lo_next_o = sq; end
            MD_DIVU:  begin hi_next_o = ur; lo_next_o = uq; end
            default:  begin hi_next_o = 32'd0; lo_next_o = 32'd0; end
        endcase

        div_by_zero_o = is_div_op(op_i) && (b_i == 32'd0);
    end

endmodule

// File: rtl/mdu_ctrl.sv
// Multiply/divide sequencer for the E stage: owns HI/LO, models fixed
// latency with a countdown and commits the result when it expires.
module mdu_ctrl
    import mdu_ctrl_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    mdu_ctrl_if.slave   md,
    output state_t      dbg_state_o
);

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               busy_q;
    logic [31:0]        hi_q;
    logic [31:0]        lo_q;
    logic [31:0]        a_q;
    logic [31:0]        b_q;
    md_op_t             op_q;

    logic [31:0]        hi_next;
    logic [31:0]        lo_next;
    logic               div_by_zero;
    logic               accept;

    mdu_ctrl_compute u_compute (
        .op_i          (op_q),
        .a_i           (a_q),
        .b_i           (b_q),
        .hi_next_o     (hi_next),
        .lo_next_o     (lo_next),
        .div_by_zero_o (div_by_zero)
    );

    assign accept = md.start && !md.kill;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            op_q    <= MD_NONE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept && is_long_op(md.md_op)) begin
                        a_q     <= md.A;
                        b_q     <= md.B;
                        op_q    <= md.md_op;
                        cnt_q   <= is_div_op(md.md_op) ? CNT_W'(DIV_CYCLES)
                                                       : CNT_W'(MULT_CYCLES);
                        state_q <= ST_RUN;
                        busy_q  <= 1'b1;
                    end else if (accept && md.md_op == MD_MTHI) begin
                        hi_q <= md.A;
                    end else if (accept && md.md_op == MD_MTLO) begin
                        lo_q <= md.A;
                    end
                end
                ST_RUN: begin
                    // Starts of any kind are dropped while running.
                    if (cnt_q == CNT_W'(1)) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                        cnt_q   <= '0;
                        if (!div_by_zero) begin
                            hi_q <= hi_next;
                            lo_q <= lo_next;
                        end
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign md.hi       = hi_q;
    assign md.lo       = lo_q;
    assign md.busy     = busy_q;
    assign md.md_stall = busy_q | (md.start & is_long_op(md.md_op) & ~md.kill);
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed bench for mdu_ctrl: a vector table of ops with hand-computed
// HI/LO and busy lengths, then kill, collision and mid-run reset sequences.
module tb_mdu_ctrl;
  import mdu_ctrl_pkg::*;

  typedef struct {
    md_op_t      op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    int          cycles;
  } vec_t;

  logic   clk;
  logic   reset;
  state_t dbg_state;
  int     n_cmp;
  int     n_fail;
  vec_t   vecs[13];

  mdu_ctrl_if md_if();

  mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk         (clk),
    .reset       (reset),
    .md          (md_if),
    .dbg_state_o (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  // Present one op for a single edge; returns at the negedge after it
  // with A/B scrambled so that operand latching is exercised.
  task automatic issue(input md_op_t op, input logic [31:0] a, input logic [31:0] b,
                       input logic k, input logic exp_stall, input string nm);
    md_if.start = 1'b1;
    md_if.md_op = op;
    md_if.A     = a;
    md_if.B     = b;
    md_if.kill  = k;
    #1;
    check({nm, " md_stall"}, {31'd0, md_if.md_stall}, {31'd0, exp_stall});
    @(negedge clk);
    md_if.start = 1'b0;
    md_if.kill  = 1'b0;
    md_if.md_op = MD_NONE;
    md_if.A     = $urandom;
    md_if.B     = $urandom;
  endtask

  task automatic wait_idle(input string nm, output int n);
    n = 0;
    while (md_if.busy && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (n >= 200) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s timeout: busy still 1 after %0d cycles, required 0", nm, n);
    end
  endtask

  initial begin
    int n;
    int total;
    n_cmp  = 0;
    n_fail = 0;

    vecs[0]  = '{MD_MTHI,  32'h0000_0011, 32'h0,         32'h0000_0011, 32'h0000_0000, 0};
    vecs[1]  = '{MD_MTLO,  32'h0000_0022, 32'h0,         32'h0000_0011, 32'h0000_0022, 0};
    vecs[2]  = '{MD_DIVU,  32'h0000_0005, 32'h0,         32'h0000_0011, 32'h0000_0022, 10};
    vecs[3]  = '{MD_DIV,   32'h0000_0007, 32'h0,         32'h0000_0011, 32'h0000_0022, 10};
    vecs[4]  = '{MD_MULT,  32'hFFFF_FFFE, 32'h3,         32'hFFFF_FFFF, 32'hFFFF_FFFA, 5};
    vecs[5]  = '{MD_MULTU, 32'hFFFF_FFFE, 32'h3,         32'h0000_0002, 32'hFFFF_FFFA, 5};
    vecs[6]  = '{MD_DIV,   32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 10};
    vecs[7]  = '{MD_DIVU,  32'hFFFF_FFF9, 32'h2,         32'h0000_0001, 32'h7FFF_FFFC, 10};
    vecs[8]  = '{MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 10};
    vecs[9]  = '{MD_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 5};
    vecs[10] = '{MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 5};
    vecs[11] = '{MD_DIV,   32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 10};
    vecs[12] = '{MD_MULT,  32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 32'h2345_6780, 5};

    md_if.start = 1'b0;
    md_if.md_op = MD_NONE;
    md_if.kill  = 1'b0;
    md_if.A     = 32'd0;
    md_if.B     = 32'd0;
    reset       = 1'b0;
    #1;
    check("reset hi", md_if.hi, 32'd0);
    check("reset lo", md_if.lo, 32'd0);
    check("reset busy", {31'd0, md_if.busy}, 32'd0);
    check("reset state", {31'd0, dbg_state}, {31'd0, ST_IDLE});
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // none with start: no effect
    issue(MD_NONE, 32'hDEAD_BEEF, 32'h1, 1'b0, 1'b0, "none");
    check("none busy", {31'd0, md_if.busy}, 32'd0);
    check("none hi", md_if.hi, 32'd0);

    for (int i = 0; i < 13; i++) begin
      string nm;
      nm = $sformatf("vec%0d", i);
      issue(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0, vecs[i].cycles != 0, nm);
      wait_idle(nm, n);
      check({nm, " cycles"}, n, vecs[i].cycles);
      check({nm, " hi"}, md_if.hi, vecs[i].exp_hi);
      check({nm, " lo"}, md_if.lo, vecs[i].exp_lo);
    end

    // kill suppresses a same-cycle start
    issue(MD_MULT, 32'h5, 32'h6, 1'b1, 1'b0, "kill");
    check("kill busy", {31'd0, md_if.busy}, 32'd0);
    @(negedge clk);
    check("kill busy later", {31'd0, md_if.busy}, 32'd0);
    check("kill hi", md_if.hi, 32'h0000_0001);
    check("kill lo", md_if.lo, 32'h2345_6780);

    // div issued while a mult is in flight is dropped
    issue(MD_MULT, 32'h10, 32'h10, 1'b0, 1'b1, "coll mult");
    @(negedge clk);
    md_if.start = 1'b1;
    md_if.md_op = MD_DIV;
    md_if.A     = 32'h1;
    md_if.B     = 32'h1;
    #1;
    check("coll div md_stall", {31'd0, md_if.md_stall}, 32'd1);
    @(negedge clk);
    md_if.start = 1'b0;
    md_if.md_op = MD_NONE;
    wait_idle("coll", n);
    total = n + 2;
    check("coll cycles", total, 5);
    check("coll hi", md_if.hi, 32'd0);
    check("coll lo", md_if.lo, 32'h0000_0100);
    @(negedge clk);
    check("coll no restart", {31'd0, md_if.busy}, 32'd0);

    // asynchronous reset in the middle of a run
    issue(MD_MULT, 32'h7, 32'h9, 1'b0, 1'b1, "rst mult");
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("midrst busy", {31'd0, md_if.busy}, 32'd0);
    check("midrst hi", md_if.hi, 32'd0);
    check("midrst lo", md_if.lo, 32'd0);
    check("midrst state", {31'd0, dbg_state}, {31'd0, ST_IDLE});
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    issue(MD_MULT, 32'h3, 32'h4, 1'b0, 1'b1, "post rst");
    wait_idle("post rst", n);
    check("post rst cycles", n, 5);
    check("post rst hi", md_if.hi, 32'd0);
    check("post rst lo", md_if.lo, 32'd12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // absolute time guard
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required finish");
    $fatal(1);
  end

endmodule
